// File: rtl/modmul_pipe.sv
// modmul_pipe: four-stage pipelined modular multiplier for the NTT/INTT
// butterfly twiddle product.
//   in_mode = 0 : Kyber, two independent 12-bit lanes, q = KQ
//   in_mode = 1 : Dilithium, one 23-bit lane, q = DQ
// Reduction is Barrett: qest = floor(p * floor(2^k / q) / 2^k), k = 24 / 46.
// With p < 2^k this undershoots floor(p/q) by at most one, so p - qest*q
// lies in [0, 2q) and one conditional subtraction gives the exact residue.
// Ports:
//   clk, rst (async, active-low)
//   in_valid / in_ready       : operand handshake (in_ready = global enable)
//   in_mode, in_a, in_b       : mode and packed operands
//   in_tag                    : sideband returned unchanged with the result
//   out_valid / out_ready     : result handshake
//   out_prod, out_mode, out_tag : registered result beat from stage 4
//   busy                      : any stage holds a valid beat
module modmul_pipe #(
    parameter int KQ    = 3329,
    parameter int DQ    = 8380417,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [23:0]      in_a,
    input  logic [23:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [23:0]      out_prod,
    output logic             out_mode,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam logic [12:0] KQ_C = 13'(KQ);
    localparam logic [23:0] DQ_C = 24'(DQ);
    localparam logic [12:0] KM_C = 13'((64'd1 << 24) / 64'(KQ));
    localparam logic [23:0] DM_C = 24'((64'd1 << 46) / 64'(DQ));

    // Barrett quotient estimate for one Kyber lane product (p < 2^24).
    function automatic logic [12:0] kyber_qest(input logic [23:0] p);
        return 13'(({13'd0, p} * {24'd0, KM_C}) >> 24);
    endfunction

    // Barrett quotient estimate for the Dilithium product (p < 2^46).
    function automatic logic [23:0] dil_qest(input logic [45:0] p);
        return 24'(({24'd0, p} * {46'd0, DM_C}) >> 46);
    endfunction

    // The true remainder is below 2q < 2^13, so mod-2^13 arithmetic is exact.
    function automatic logic [12:0] kyber_rem(input logic [12:0] p_lo, input logic [12:0] qe);
        logic [12:0] m;
        m = qe * KQ_C;
        return p_lo - m;
    endfunction

    // The true remainder is below 2q < 2^24, so mod-2^24 arithmetic is exact.
    function automatic logic [23:0] dil_rem(input logic [23:0] p_lo, input logic [23:0] qe);
        logic [23:0] m;
        m = qe * DQ_C;
        return p_lo - m;
    endfunction

    function automatic logic [11:0] kyber_fix(input logic [12:0] r);
        return 12'((r >= KQ_C) ? (r - KQ_C) : r);
    endfunction

    function automatic logic [22:0] dil_fix(input logic [23:0] r);
        return 23'((r >= DQ_C) ? (r - DQ_C) : r);
    endfunction

    logic             en_s;
    logic [47:0]      p1_s;
    logic [25:0]      q2_s;
    logic [25:0]      r3_s;
    logic [23:0]      o4_s;

    logic             v1_r, v2_r, v3_r, v4_r;
    logic             m1_r, m2_r, m3_r, m4_r;
    logic [TAG_W-1:0] t1_r, t2_r, t3_r, t4_r;
    logic [47:0]      p1_r;   // Kyber {hi, lo} 24-bit products; Dilithium 46-bit product
    logic [36:0]      p2_r;   // only the product bits the remainder step needs
    logic [25:0]      q2_r;   // Kyber {qhi, qlo} 13-bit; Dilithium {2'b0, q[23:0]}
    logic [25:0]      r3_r;   // Kyber {rhi, rlo} 13-bit; Dilithium {2'b0, r[23:0]}
    logic [23:0]      o4_r;

    assign en_s      = out_ready | ~v4_r;
    assign in_ready  = en_s;
    assign out_valid = v4_r;
    assign out_prod  = o4_r;
    assign out_mode  = m4_r;
    assign out_tag   = t4_r;
    assign busy      = v1_r | v2_r | v3_r | v4_r;

    // Stage 1 input: raw product(s) of the incoming operands.
    always_comb begin
        p1_s = 48'd0;
        if (in_mode) begin
            p1_s = {2'b00, {23'd0, in_a[22:0]} * {23'd0, in_b[22:0]}};
        end else begin
            p1_s = {{12'd0, in_a[23:12]} * {12'd0, in_b[23:12]},
                    {12'd0, in_a[11:0]}  * {12'd0, in_b[11:0]}};
        end
    end

    // Stage 2 input: quotient estimate(s) from the stage 1 product.
    always_comb begin
        q2_s = 26'd0;
        if (m1_r) begin
            q2_s = {2'b00, dil_qest(p1_r[45:0])};
        end else begin
            q2_s = {kyber_qest(p1_r[47:24]), kyber_qest(p1_r[23:0])};
        end
    end

    // Stage 3 input: product minus estimate times modulus, per lane.
    always_comb begin
        r3_s = 26'd0;
        if (m2_r) begin
            r3_s = {2'b00, dil_rem(p2_r[23:0], q2_r[23:0])};
        end else begin
            r3_s = {kyber_rem(p2_r[36:24], q2_r[25:13]), kyber_rem(p2_r[12:0], q2_r[12:0])};
        end
    end

    // Stage 4 input: final conditional subtraction into [0, q).
    always_comb begin
        o4_s = 24'd0;
        if (m3_r) begin
            o4_s = {1'b0, dil_fix(r3_r[23:0])};
        end else begin
            o4_s = {kyber_fix(r3_r[25:13]), kyber_fix(r3_r[12:0])};
        end
    end

    // Pipeline registers: all stages advance together on the global enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_r <= 1'b0;          v2_r <= 1'b0;          v3_r <= 1'b0;          v4_r <= 1'b0;
            m1_r <= 1'b0;          m2_r <= 1'b0;          m3_r <= 1'b0;          m4_r <= 1'b0;
            t1_r <= {TAG_W{1'b0}}; t2_r <= {TAG_W{1'b0}}; t3_r <= {TAG_W{1'b0}}; t4_r <= {TAG_W{1'b0}};
            p1_r <= 48'd0;
            p2_r <= 37'd0;
            q2_r <= 26'd0;
            r3_r <= 26'd0;
            o4_r <= 24'd0;
        end else if (en_s) begin
            v1_r <= in_valid & in_ready;
            m1_r <= in_mode;
            t1_r <= in_tag;
            p1_r <= p1_s;
            v2_r <= v1_r;
            m2_r <= m1_r;
            t2_r <= t1_r;
            p2_r <= p1_r[36:0];
            q2_r <= q2_s;
            v3_r <= v2_r;
            m3_r <= m2_r;
            t3_r <= t2_r;
            r3_r <= r3_s;
            v4_r <= v3_r;
            m4_r <= m3_r;
            t4_r <= t3_r;
            o4_r <= o4_s;
        end else begin
            v4_r <= v4_r;
        end
    end

endmodule

// File: tb/tb_modmul_pipe.sv
module tb_modmul_pipe;
    localparam int TAG_W = 8;
    localparam longint unsigned KQ_M = 64'd3329;
    localparam longint unsigned DQ_M = 64'd8380417;

    typedef struct {
        logic             mode;
        logic [23:0]      a;
        logic [23:0]      b;
        logic [TAG_W-1:0] tag;
    } beat_t;

    typedef struct {
        logic  valid;
        beat_t beat;
    } slot_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_mode = 1'b0;
    logic [23:0]      in_a = 24'd0;
    logic [23:0]      in_b = 24'd0;
    logic [TAG_W-1:0] in_tag = 8'd0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [23:0]      out_prod;
    logic             out_mode;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    modmul_pipe #(.KQ(3329), .DQ(8380417), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .out_mode(out_mode), .out_tag(out_tag),
        .busy(busy)
    );

    // Reference: plain modular multiplication on 64-bit integers.
    function automatic logic [23:0] golden(input beat_t bt);
        longint unsigned x, y, h, l;
        if (bt.mode) begin
            x = {41'd0, bt.a[22:0]};
            y = {41'd0, bt.b[22:0]};
            l = (x * y) % DQ_M;
            return {1'b0, l[22:0]};
        end else begin
            x = {52'd0, bt.a[23:12]};
            y = {52'd0, bt.b[23:12]};
            h = (x * y) % KQ_M;
            x = {52'd0, bt.a[11:0]};
            y = {52'd0, bt.b[11:0]};
            l = (x * y) % KQ_M;
            return {h[11:0], l[11:0]};
        end
    endfunction

    function automatic beat_t rand_beat(input logic mode, input logic [TAG_W-1:0] tag);
        beat_t bt;
        bt.mode = mode;
        bt.tag  = tag;
        if (mode) begin
            bt.a = {1'b0, 23'($urandom_range(0, 8380416))};
            bt.b = {1'b0, 23'($urandom_range(0, 8380416))};
        end else begin
            bt.a = {12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328))};
            bt.b = {12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328))};
        end
        return bt;
    endfunction

    function automatic beat_t idle_beat();
        beat_t bt;
        bt.mode = 1'b0; bt.a = 24'd0; bt.b = 24'd0; bt.tag = 8'd0;
        return bt;
    endfunction

    task automatic drive(input logic v, input beat_t bt);
        in_valid = v;
        in_mode  = bt.mode;
        in_a     = bt.a;
        in_b     = bt.b;
        in_tag   = bt.tag;
    endtask

    task automatic test_reset();
        beat_t bt;
        bt = '{1'b1, 24'd5, 24'd7, 8'h33};
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, bt);
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        total++; if (out_prod !== 24'd0) begin bad++; $display("FAIL rst_out_prod: got %0h want 0", out_prod); end
        total++; if (out_tag !== 8'd0 || out_mode !== 1'b0) begin bad++; $display("FAIL rst_tag_mode: got %0h/%b want 0/0", out_tag, out_mode); end
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            drive(1'b0, idle_beat());
            if (k != 4) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_first_latency k=%0d: got valid %b want 0", k, out_valid); end
            end else begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_first_valid: got %b want 1", out_valid); end
                total++; if (out_prod !== 24'd35 || out_tag !== 8'h33) begin bad++; $display("FAIL rst_first_beat: got %0d/%0h want 35/33", out_prod, out_tag); end
            end
        end
    endtask

    task automatic test_kyber_lanes();
        beat_t bt;
        bt = '{1'b0, {12'd3328, 12'd17}, {12'd3328, 12'd1729}, 8'h5A};
        out_ready = 1'b1;
        drive(1'b1, bt);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            drive(1'b0, idle_beat());
            if (k != 4) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL kyber_latency k=%0d: got valid %b want 0", k, out_valid); end
            end else begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL kyber_valid: got %b want 1", out_valid); end
                total++; if (out_prod !== {12'd1, 12'd2761}) begin bad++; $display("FAIL kyber_prod: got %0h want %0h", out_prod, {12'd1, 12'd2761}); end
                total++; if (out_tag !== 8'h5A || out_mode !== 1'b0) begin bad++; $display("FAIL kyber_tag_mode: got %0h/%b want 5a/0", out_tag, out_mode); end
            end
        end
    endtask

    task automatic test_dilithium();
        beat_t       bts[3];
        logic [23:0] want[3];
        bts[0] = '{1'b1, 24'd8380416, 24'd8380416, 8'hD0};
        bts[1] = '{1'b1, 24'd2, 24'd4190209, 8'hD1};
        bts[2] = '{1'b1, 24'd0, 24'd123, 8'hD2};
        want[0] = 24'd1; want[1] = 24'd1; want[2] = 24'd0;
        out_ready = 1'b1;
        for (int it = 0; it < 8; it++) begin
            if (it >= 4 && it < 7) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dil_valid it=%0d: got %b want 1", it, out_valid); end
                total++; if (out_prod !== want[it-4]) begin bad++; $display("FAIL dil_prod it=%0d: got %0d want %0d", it, out_prod, want[it-4]); end
                total++; if (out_prod !== golden(bts[it-4])) begin bad++; $display("FAIL dil_golden it=%0d: got %0d want %0d", it, out_prod, golden(bts[it-4])); end
                total++; if (out_tag !== bts[it-4].tag || out_mode !== 1'b1) begin bad++; $display("FAIL dil_tag_mode it=%0d: got %0h/%b want %0h/1", it, out_tag, out_mode, bts[it-4].tag); end
            end else begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dil_gap it=%0d: got valid %b want 0", it, out_valid); end
            end
            if (it < 3) drive(1'b1, bts[it]);
            else drive(1'b0, idle_beat());
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        beat_t src[8];
        beat_t exp_q[$];
        beat_t hd;
        int    next = 0;
        int    got = 0;
        int    hold_left = 0;
        int    hold_cycles = 0;
        logic  held = 1'b0;
        logic  orv;
        logic  want_ready;
        for (int i = 0; i < 8; i++) src[i] = rand_beat(1'(i % 2), 8'(i));
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            orv = 1'b1;
            if (!held && out_valid === 1'b1 && exp_q.size() > 0 && exp_q[0].tag == 8'd1) begin
                held = 1'b1;
                hold_left = 3;
            end
            if (hold_left > 0) begin
                orv = 1'b0;
                hold_left--;
                hold_cycles++;
            end
            out_ready = orv;
            #1;
            want_ready = orv | ~out_valid;
            total++; if (in_ready !== want_ready) begin bad++; $display("FAIL bp_in_ready cyc=%0d: got %b want %b", cyc, in_ready, want_ready); end
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++; bad++; $display("FAIL bp_spurious cyc=%0d: got tag %0h want no beat", cyc, out_tag);
                end else begin
                    if (orv) hd = exp_q.pop_front();
                    else hd = exp_q[0];
                    total++; if (out_tag !== hd.tag) begin bad++; $display("FAIL bp_tag cyc=%0d: got %0h want %0h", cyc, out_tag, hd.tag); end
                    total++; if (out_prod !== golden(hd) || out_mode !== hd.mode) begin bad++; $display("FAIL bp_data cyc=%0d: got %0h/%b want %0h/%b", cyc, out_prod, out_mode, golden(hd), hd.mode); end
                    if (orv) got++;
                end
            end
            if (next < 8) begin
                drive(1'b1, src[next]);
                if (want_ready) begin
                    exp_q.push_back(src[next]);
                    next++;
                end
            end else begin
                drive(1'b0, idle_beat());
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        drive(1'b0, idle_beat());
        total++; if (got !== 8) begin bad++; $display("FAIL bp_count: got %0d want 8", got); end
        total++; if (hold_cycles !== 3) begin bad++; $display("FAIL bp_hold_seen: got %0d want 3", hold_cycles); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_mixed_bubbles();
        slot_t pend[$];
        slot_t s;
        beat_t bt;
        logic  next_mode = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 15004; c++) begin
            if (c >= 4) begin
                s = pend.pop_front();
                total++;
                if (out_valid !== s.valid) begin
                    bad++; $display("FAIL mix_slot c=%0d: got valid %b want %b", c, out_valid, s.valid);
                end else if (s.valid) begin
                    total++; if (out_mode !== s.beat.mode) begin bad++; $display("FAIL mix_mode c=%0d: got %b want %b", c, out_mode, s.beat.mode); end
                    total++; if (out_tag !== s.beat.tag) begin bad++; $display("FAIL mix_tag c=%0d: got %0h want %0h", c, out_tag, s.beat.tag); end
                    total++; if (out_prod !== golden(s.beat)) begin bad++; $display("FAIL mix_prod c=%0d: got %0h want %0h", c, out_prod, golden(s.beat)); end
                end
            end
            if (c < 15000) begin
                if ((c % 3) != 2) begin
                    bt = rand_beat(next_mode, 8'(c));
                    next_mode = ~next_mode;
                    drive(1'b1, bt);
                    s.valid = 1'b1;
                    s.beat  = bt;
                end else begin
                    drive(1'b0, idle_beat());
                    s.valid = 1'b0;
                    s.beat  = idle_beat();
                end
                pend.push_back(s);
            end else begin
                drive(1'b0, idle_beat());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_midstream_reset();
        beat_t bt;
        out_ready = 1'b1;
        for (int it = 0; it < 4; it++) begin
            if (it == 1) begin
                drive(1'b0, idle_beat());
            end else begin
                bt = rand_beat(1'(it % 2), 8'hE0 + 8'(it));
                drive(1'b1, bt);
            end
            @(negedge clk);
        end
        drive(1'b0, idle_beat());
        total++; if (out_valid !== 1'b1 || out_tag !== 8'hE0) begin bad++; $display("FAIL midrst_pre: got %b/%0h want 1/e0", out_valid, out_tag); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        total++; if (out_tag !== 8'd0 || out_prod !== 24'd0) begin bad++; $display("FAIL midrst_regs: got %0h/%0h want 0/0", out_tag, out_prod); end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_ghost k=%0d: got valid %b busy %b want 0 0", k, out_valid, busy); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_kyber_lanes();
        test_dilithium();
        test_back_to_back();
        test_mixed_bubbles();
        test_midstream_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
